// File: rtl/ccff_loader.sv
// Configuration-chain programming controller: serialises host words MSB-first onto ccff_head,
// then optionally recirculates the chain once and compares CRC-16-CCITT of the tail stream.
module ccff_loader #(
  parameter int unsigned CHAIN_LEN = 36,
  parameter int unsigned DATA_W    = 8,
  parameter bit          VERIFY_EN = 1'b1
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WbW  = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] LastBit  = CntW'(CHAIN_LEN - 1);
  localparam logic [WbW-1:0]  WordBits = WbW'(DATA_W);
  localparam logic [15:0]     CrcInit  = 16'hFFFF;

  typedef enum logic [1:0] {StIdle, StLoad, StVerify, StDone} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] hold_q;
  logic [WbW-1:0]    wbits_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [15:0]       load_crc_q, vrf_crc_q;
  logic [15:0]       load_crc_next, vrf_crc_next;
  logic              done_q, err_q;
  logic              load_shift, accept;
  int unsigned       pending;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // All outputs decode registered state only; ccff_tail is itself a chain flop.
  always_comb begin
    load_shift    = (state_q == StLoad) && (wbits_q != '0);
    ccff_shift_en = load_shift || (state_q == StVerify);
    ccff_head     = 1'b0;
    if (state_q == StVerify)    ccff_head = ccff_tail;
    else if (state_q == StLoad) ccff_head = hold_q[DATA_W-1];
    pending       = 32'(bit_cnt_q) + 32'(wbits_q);
    in_ready      = (state_q == StLoad) && (wbits_q <= WbW'(1)) && (pending < CHAIN_LEN);
    accept        = in_valid && in_ready;
    busy          = (state_q == StLoad) || (state_q == StVerify);
    done          = done_q;
    err           = err_q;
    load_crc_next = crc_step(load_crc_q, ccff_head);
    vrf_crc_next  = crc_step(vrf_crc_q, ccff_tail);
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      wbits_q    <= '0;
      bit_cnt_q  <= '0;
      load_crc_q <= CrcInit;
      vrf_crc_q  <= CrcInit;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (abort) begin
      state_q <= StIdle;
      wbits_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b1;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StLoad;
            wbits_q    <= '0;
            bit_cnt_q  <= '0;
            load_crc_q <= CrcInit;
            vrf_crc_q  <= CrcInit;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        StLoad: begin
          if (load_shift) begin
            hold_q     <= hold_q << 1;
            wbits_q    <= wbits_q - 1'b1;
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            load_crc_q <= load_crc_next;
          end
          // A new word lands on the same edge as the previous word's final bit.
          if (accept) begin
            hold_q  <= in_data;
            wbits_q <= WordBits;
          end
          if (load_shift && (bit_cnt_q == LastBit)) begin
            wbits_q   <= '0;
            bit_cnt_q <= '0;
            if (VERIFY_EN) begin
              state_q <= StVerify;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StVerify: begin
          vrf_crc_q <= vrf_crc_next;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastBit) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            err_q   <= (vrf_crc_next != load_crc_q);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: 36-bit chain model, host driver, and expectations built from the word
// stream (first bit ends at the tail) and from cycle counts of the load/verify sequence.
module tb_ccff_loader;

  logic       prog_clk = 1'b0;
  logic       prog_rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, ccff_head, ccff_tail, ccff_shift_en, busy, done, err;

  logic [35:0] chain = '0;
  logic [35:0] flip_mask = '0;
  int n_cmp = 0, n_bad = 0;
  int n_acc = 0, n_shift = 0, n_gap = 0;
  logic [7:0] words [5];

  ccff_loader #(.CHAIN_LEN(36), .DATA_W(8), .VERIFY_EN(1'b1)) dut (
    .prog_clk      (prog_clk),
    .prog_rst_n    (prog_rst_n),
    .start         (start),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .ccff_shift_en (ccff_shift_en),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 prog_clk = ~prog_clk;

  assign ccff_tail = chain[35];

  // Chain model plus event counters observed at each active edge.
  always @(posedge prog_clk) begin
    if (ccff_shift_en) chain <= {chain[34:0], ccff_head} ^ flip_mask;
    else               chain <= chain ^ flip_mask;
    if (in_valid && in_ready)    n_acc   <= n_acc + 1;
    if (ccff_shift_en)           n_shift <= n_shift + 1;
    if (busy && !ccff_shift_en)  n_gap   <= n_gap + 1;
  end

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 64'({in_ready, ccff_head, ccff_shift_en, busy, done, err}), 64'd0);
  endtask

  function automatic logic [35:0] exp_chain();
    logic [39:0] s;
    s = {words[0], words[1], words[2], words[3], words[4]};
    return s[39:4];
  endfunction

  // Full load of words[], optional host stall before word stall_at, optional chain bit flip
  // on the first VERIFY cycle (flip_q = 0 means none).
  task automatic run_load(input string tag, input int stall_at, input int stall_len,
                          input int flip_q);
    int g, s0, a0, gp0, cyc;
    bit flipped;
    s0 = n_shift; a0 = n_acc; gp0 = n_gap;
    start = 1'b1; tick(); start = 1'b0; cyc = 0;
    chk({tag, "_err_cleared"}, 64'({busy, done, err}), 64'b100);
    for (int i = 0; i < 5; i++) begin
      if (i == stall_at) begin
        in_valid = 1'b0; g = 0;
        while (!in_ready && g < 100) begin tick(); cyc++; g++; end
        repeat (stall_len) begin tick(); cyc++; end
      end
      in_valid = 1'b1; in_data = words[i]; g = 0;
      while (!in_ready && g < 100) begin tick(); cyc++; g++; end
      tick(); cyc++;
    end
    in_data = 8'($urandom);
    chk({tag, "_ready_after_last"}, 64'(in_ready), 64'd0);
    flipped = 1'b0; g = 0;
    while (!done && g < 300) begin
      if (flip_q != 0 && !flipped && (n_shift - s0) == 36) begin
        flip_mask[flip_q] = 1'b1;
        flipped = 1'b1;
      end
      tick(); flip_mask = '0; cyc++; g++;
    end
    in_valid = 1'b0;
    chk({tag, "_done"}, 64'({busy, done}), 64'b01);
    chk({tag, "_err"}, 64'(err), 64'(flip_q != 0));
    chk({tag, "_cycles"}, 64'(cyc), 64'(73 + stall_len));
    chk({tag, "_accepts"}, 64'(n_acc - a0), 64'd5);
    chk({tag, "_shifts"}, 64'(n_shift - s0), 64'd72);
    chk({tag, "_gaps"}, 64'(n_gap - gp0), 64'(1 + stall_len));
    if (flip_q == 0) chk({tag, "_chain"}, 64'(chain), 64'(exp_chain()));
  endtask

  // Load with a constant word presented continuously; returns once shifts reach target.
  task automatic const_load_until(input int target, output int s0);
    int g;
    s0 = n_shift;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A; g = 0;
    while ((n_shift - s0) < target && g < 200) begin tick(); g++; end
    chk("const_load_reach", 64'(n_shift - s0 >= target), 64'd1);
  endtask

  initial begin
    int s0, a0, g;
    #1;
    chk_zero("reset_outputs");
    #10 prog_rst_n = 1'b1;
    tick();

    // in_valid while IDLE is ignored
    s0 = n_shift; a0 = n_acc;
    in_valid = 1'b1; in_data = 8'hC3;
    repeat (5) tick();
    in_valid = 1'b0;
    chk("idle_valid_acc", 64'(n_acc - a0), 64'd0);
    chk("idle_valid_shift", 64'(n_shift - s0), 64'd0);

    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h9F};
    run_load("basic", -1, 0, 0);
    chk("basic_stream", 64'(chain), 64'h0_A53C_FF00_9);
    run_load("stall", 2, 3, 0);
    run_load("corrupt", -1, 0, int'($urandom_range(35, 1)));

    // Abort after 20 LOAD shifts
    const_load_until(20, s0);
    abort = 1'b1; tick(); abort = 1'b0; in_valid = 1'b0;
    chk("abort_state", 64'({busy, ccff_shift_en, in_ready, done, err}), 64'b00001);
    run_load("after_abort", -1, 0, 0);

    // start while busy (in LOAD and in VERIFY) is ignored
    const_load_until(10, s0);
    start = 1'b1; tick(); start = 1'b0;
    g = 0;
    while ((n_shift - s0) < 50 && g < 200) begin tick(); g++; end
    start = 1'b1; tick(); start = 1'b0;
    g = 0;
    while (!done && g < 200) begin tick(); g++; end
    in_valid = 1'b0;
    words = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    chk("busy_start_shifts", 64'(n_shift - s0), 64'd72);
    chk("busy_start_flags", 64'({done, err}), 64'b10);
    chk("busy_start_chain", 64'(chain), 64'(exp_chain()));

    // Asynchronous reset mid-VERIFY
    const_load_until(50, s0);
    #2 prog_rst_n = 1'b0;
    #1 chk_zero("async_reset");
    in_valid = 1'b0;
    #2 prog_rst_n = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) words[k] = 8'($urandom);
    run_load("after_reset", -1, 0, 0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) words[k] = 8'($urandom);
      run_load("random", int'($urandom_range(4, 1)), int'($urandom_range(4, 1)),
               (r == 2) ? int'($urandom_range(35, 1)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
Name: ccff_loader

Overview:
- Configuration-chain programming controller that drives ccff_head of the first switch/connection block in the fabric's configuration chain, and observes ccff_tail of the last one.
- Accepts configuration words from an upstream host over a valid/ready handshake and serialises them MSB-first onto the chain, one bit per enabled prog_clk cycle.
- Optional verify pass recirculates the chain once; a CRC of the bits leaving ccff_tail is compared with the CRC taken at load time.

Parameters:
- CHAIN_LEN, 36, total configuration bits in the chain (a single sb with 18 two-bit mems = 36).
- DATA_W, 8, host word width.
- VERIFY_EN, 1, 1 = run a verify pass after load; 0 = go straight to DONE.

Ports:
- prog_clk  input  1  programming clock; all flops rise-edge.
- prog_rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a load; sampled only in IDLE or DONE.
- abort  input  1  synchronous cancel; takes priority over all other inputs except reset.
- in_valid  input  1  host word valid.
- in_data  input  DATA_W  host word; bit DATA_W-1 is shifted first.
- in_ready  output  1  loader accepts in_data this cycle.
- ccff_head  output  1  serial data into the chain.
- ccff_tail  input  1  serial data out of the last chain flop.
- ccff_shift_en  output  1  chain clock-enable; the chain advances on a rising prog_clk edge only while this is 1.
- busy  output  1  high in LOAD or VERIFY.
- done  output  1  level; set when the sequence completes, cleared by start or abort.
- err  output  1  level; CRC mismatch or abort; cleared by start.

Behaviour:
- Reset values: all outputs 0, state IDLE, crc registers 16'hFFFF, all counters 0. Reset mid-operation stops shifting immediately; chain contents are then undefined.
- States:
  - IDLE/DONE -> LOAD on start. The start cycle clears done/err, bit_cnt and wbits, and initialises both CRCs to 16'hFFFF.
  - LOAD -> VERIFY (VERIFY_EN=1) or DONE (VERIFY_EN=0) on the cycle the CHAIN_LEN-th bit shifts.
  - VERIFY -> DONE after CHAIN_LEN shifts.
  - Any state -> IDLE on abort, with err=1 and done=0.
- LOAD:
  - Holding register hold[DATA_W-1:0] with remaining-bit count wbits.
  - ccff_shift_en = (state==LOAD && wbits!=0); ccff_head = hold[DATA_W-1].
  - On each shift: hold <<= 1, wbits--, bit_cnt++, load_crc updated with ccff_head.
  - in_ready = LOAD && wbits<=1 && (bit_cnt + wbits) < CHAIN_LEN.
  - On in_valid && in_ready: hold <= in_data, wbits <= DATA_W, in the same edge as any final-bit shift. This allows back-to-back words with no bubble.
  - Host stall: wbits==0 gives shift_en=0, and the chain holds.
  - If CHAIN_LEN is not a multiple of DATA_W, the low bits of the last word are never shifted. Leaving LOAD discards them and clears wbits. in_ready is never asserted again after the last needed word.
- VERIFY:
  - ccff_shift_en=1 every cycle, ccff_head = ccff_tail (recirculate).
  - vrf_crc is updated with ccff_tail before each edge.
  - After exactly CHAIN_LEN shifts the chain is restored to its loaded contents.
  - On entry to DONE: err <= (vrf_crc_next != load_crc).
- CRC: serial CRC-16-CCITT, poly 0x1021, init 0xFFFF. fb = crc[15]^bit; crc <= {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
- Counters:
  - bit_cnt width is clog2(CHAIN_LEN+1). It saturates at CHAIN_LEN and is reused for VERIFY (cleared on LOAD exit).
- Glitch-free outputs: ccff_shift_en, ccff_head (LOAD) and in_ready depend on registers only. ccff_head in VERIFY is ccff_tail, which is a flop output in the chain.
- Edge cases:
  - start while busy is ignored.
  - in_valid outside LOAD is ignored.
  - start and abort in the same cycle: abort wins.
  - DONE with start re-enters LOAD.

Test Plan:
All scenarios use CHAIN_LEN=36, DATA_W=8, VERIFY_EN=1, with a 36-bit shift-register chain model (tail = bit 35, enabled by ccff_shift_en).
- Basic load: start, then send 0xA5 0x3C 0xFF 0x00 0x9F with in_valid held high. Required: 36 LOAD shifts in 36 consecutive cycles after the first accept. in_ready is low after the 5th accept, and the last 4 bits of 0x9F are unused. Model holds bit stream A53CFF009 with first bit at tail. 36 VERIFY cycles follow, then done=1, err=0, and the model is unchanged.
- Host stall: same data, with in_valid dropped for 3 cycles between words 2 and 3. Required: ccff_shift_en low for exactly those cycles, and the final chain content is identical to the basic-load scenario.
- Corrupt chain: force one model bit flip during VERIFY. Required: done=1, err=1.
- Abort: assert abort after 20 LOAD shifts. Required: next cycle state IDLE, ccff_shift_en=0, busy=0, err=1, done=0. A following start clears err and a full load passes.
- Reset mid-VERIFY: pull prog_rst_n low asynchronously. Required: all outputs 0 immediately, without waiting for a clock edge. start after release runs a normal load.
- Start while busy, and in_valid while IDLE: required to be ignored, with no accepts and no shifts.
